des_cipher_uart_tx: RTL and testbench

Downstream consumer of the DES inverse-initial-permutation stage. It captures the 64-bit CIPHER_TEXT through a valid/ready handshake into a holding register. It then serialises the value onto the UART line as 8 back-to-back 8N1 frames, most-significant byte first. It owns baud timing, byte sequencing and line idle state, so the DES core never stalls on the serial link beyond one handshake.

---
 rtl/des_uart_pkg.sv | 38 +++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/des_cipher_uart_tx.sv | 148 ++++++++++++++
 tb/tb_des_cipher_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_uart_pkg.sv
// Shared state encoding, frame geometry and bit helpers for the DES ciphertext UART transmitter.
// DES_TX_PARITY_EN adds an even-parity bit (and its PARITY state) after the data bits.
package des_uart_pkg;

`ifdef DES_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;
  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } tx_state_t;
  localparam int FRAME_BITS = 10;
`endif

  localparam int NUM_BYTES = 8;
  localparam int DATA_BITS = 8;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] select_byte(input logic [63:0] word, input logic [2:0] idx);
    logic [63:0] shifted;
    shifted = word << {idx, 3'b000};
    return shifted[63:56];
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses on the last clock of every CLKS_PER_BIT-cycle bit period.
// restart realigns the period so a new frame starts on a full bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Free-running modulo counter, realigned on restart.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {CW{1'b0}};
    end else if (restart) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bit_tick = (cnt_r == LAST);

endmodule

// File: rtl/des_cipher_uart_tx.sv
// Captures a 64-bit DES ciphertext by valid/ready and sends it as eight back-to-back UART frames, MSB byte first.
// Define DES_TX_PARITY_EN for 8E1 frames; default build sends 8N1.
module des_cipher_uart_tx
  import des_uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [64:1] CIPHER_TEXT,
  input  logic        CIPHER_VALID,
  output logic        CIPHER_READY,
  output logic        TXD,
  output logic        BUSY
);

  tx_state_t   state_r, state_s;
  logic [2:0]  byte_cnt_r, byte_cnt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [63:0] hold_r;
  logic [7:0]  cur_byte_s;
  logic        txd_s;
  logic        transfer_s;
  logic        bit_tick_s;

  assign transfer_s = CIPHER_VALID && CIPHER_READY;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK     (CLK),
    .RST     (RST),
    .restart (transfer_s),
    .bit_tick(bit_tick_s)
  );

  // Next-state and counter sequencing; everything past IDLE moves only on bit_tick.
  always_comb begin
    state_s    = state_r;
    byte_cnt_s = byte_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (transfer_s) begin
          state_s    = ST_START;
          byte_cnt_s = 3'd0;
          bit_cnt_s  = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          state_s   = ST_DATA;
          bit_cnt_s = 3'd0;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
`ifdef DES_TX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef DES_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick_s) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick_s) begin
          if (byte_cnt_r == 3'(NUM_BYTES - 1)) begin
            state_s = ST_IDLE;
          end else begin
            state_s    = ST_START;
            byte_cnt_s = byte_cnt_r + 3'd1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle, so TXD itself can be a register.
  always_comb begin
    cur_byte_s = select_byte(hold_r, byte_cnt_s);
    txd_s      = 1'b1;
    case (state_s)
      ST_START:  txd_s = 1'b0;
      ST_DATA:   txd_s = cur_byte_s[bit_cnt_s];
`ifdef DES_TX_PARITY_EN
      ST_PARITY: txd_s = even_parity(cur_byte_s);
`endif
      default:   txd_s = 1'b1;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      byte_cnt_r   <= 3'd0;
      bit_cnt_r    <= 3'd0;
      TXD          <= 1'b1;
      BUSY         <= 1'b0;
      CIPHER_READY <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_cnt_r   <= byte_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      TXD          <= txd_s;
      BUSY         <= (state_s != ST_IDLE);
      CIPHER_READY <= (state_s == ST_IDLE);
    end
  end

  // Ciphertext is sampled only on the transfer edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_r <= 64'd0;
    end else if (transfer_s) begin
      hold_r <= CIPHER_TEXT;
    end else begin
      hold_r <= hold_r;
    end
  end

endmodule

// File: tb/tb_des_cipher_uart_tx.sv
// Directed bench for des_cipher_uart_tx at CLKS_PER_BIT=10: UART decode, handshake timing, reset behaviour.
// Build with DES_TX_PARITY_EN defined to check the parity variant.
module tb_des_cipher_uart_tx;

  localparam int CPB = 10;
`ifdef DES_TX_PARITY_EN
  localparam int FRAME     = 11;
  localparam int READY_LAT = 881;
`else
  localparam int FRAME     = 10;
  localparam int READY_LAT = 801;
`endif

  logic        clk;
  logic        rst;
  logic [64:1] cipher_text;
  logic        cipher_valid;
  logic        cipher_ready;
  logic        txd;
  logic        busy;

  int cyc    = 0;
  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [63:0] word;
    logic [63:0] exp_seq;  // expected bytes in line order, first byte in [63:56]
    logic [7:0]  exp_par;  // expected parity bit per byte, byte 0 in bit 7
  } vec_t;

  vec_t vecs[3];

  des_cipher_uart_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .CIPHER_TEXT (cipher_text),
    .CIPHER_VALID(cipher_valid),
    .CIPHER_READY(cipher_ready),
    .TXD         (txd),
    .BUSY        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer a word and return at the negedge after the accepting edge.
  task automatic send(input logic [63:0] w, output int acc_c);
    int n;
    n = 0;
    cipher_text  = w;
    cipher_valid = 1'b1;
    @(negedge clk);
    while (!cipher_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {63'd0, cipher_ready}, 64'd1);
    acc_c = cyc;
    @(negedge clk);
    cipher_valid = 1'b0;
  endtask

  task automatic wait_ready(output int rdy_c);
    int n;
    n = 0;
    while (!cipher_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {63'd0, cipher_ready}, 64'd1);
    rdy_c = cyc;
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic par, output logic stop,
                           output int start_c, output logic ok);
    int n;
    n = 0;
    b = 8'd0; par = 1'b0; stop = 1'b0; start_c = 0;
    while (txd !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (txd === 1'b0);
    if (ok) begin
      start_c = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
`ifdef DES_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      par = txd;
`endif
      repeat (CPB) @(negedge clk);
      stop = txd;
    end
  endtask

  task automatic recv_word(input string name, input logic [63:0] exp_seq, input logic [7:0] exp_par);
    logic [7:0] b;
    logic [63:0] seq;
    logic par, stop, ok;
    int start_c, prev_c;
    seq = exp_seq;
    prev_c = 0;
    for (int k = 0; k < 8; k++) begin
      recv_byte(b, par, stop, start_c, ok);
      check({name, "_start_timeout"}, {63'd0, ok}, 64'd1);
      if (!ok) return;
      check($sformatf("%s_byte%0d", name, k), {56'd0, b}, {56'd0, seq[63-8*k -: 8]});
      check($sformatf("%s_stop%0d", name, k), {63'd0, stop}, 64'd1);
`ifdef DES_TX_PARITY_EN
      check($sformatf("%s_par%0d", name, k), {63'd0, par}, {63'd0, exp_par[7-k]});
`else
      if (par !== 1'b0 || exp_par === 8'hxx) check({name, "_nopar"}, {63'd0, par}, 64'd0);
`endif
      if (k > 0) check($sformatf("%s_gap%0d", name, k), 64'(start_c - prev_c), 64'(FRAME * CPB));
      prev_c = start_c;
    end
  endtask

  initial begin
    int acc_c, acc2_c, rdy_c, falls;
    logic prev;

    vecs[0] = '{word: 64'h85E813540F0AB405, exp_seq: 64'h85E813540F0AB405, exp_par: 8'b10110000};
    vecs[1] = '{word: 64'h8000000000000001, exp_seq: 64'h8000000000000001, exp_par: 8'b10000001};
    vecs[2] = '{word: 64'h00000000000000A5, exp_seq: 64'h00000000000000A5, exp_par: 8'b00000000};

    rst          = 1'b1;
    cipher_valid = 1'b0;
    cipher_text  = 64'd0;

    // Reset held five cycles: line idle, not busy, not ready.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_txd", {63'd0, txd}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_ready", {63'd0, cipher_ready}, 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("release_ready", {63'd0, cipher_ready}, 64'd1);
    check("release_txd", {63'd0, txd}, 64'd1);
    check("release_busy", {63'd0, busy}, 64'd0);

    // Table of single words.
    for (int v = 0; v < 3; v++) begin
      send(vecs[v].word, acc_c);
      check($sformatf("v%0d_first_txd", v), {63'd0, txd}, 64'd0);
      check($sformatf("v%0d_busy", v), {63'd0, busy}, 64'd1);
      check($sformatf("v%0d_ready_low", v), {63'd0, cipher_ready}, 64'd0);
      recv_word($sformatf("v%0d", v), vecs[v].exp_seq, vecs[v].exp_par);
      wait_ready(rdy_c);
      check($sformatf("v%0d_ready_lat", v), 64'(rdy_c - acc_c), 64'(READY_LAT));
      check($sformatf("v%0d_idle_busy", v), {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back with CIPHER_VALID held high.
    cipher_text  = 64'h0123456789ABCDEF;
    cipher_valid = 1'b1;
    @(negedge clk);
    while (!cipher_ready) @(negedge clk);
    acc_c = cyc;
    @(negedge clk);
    cipher_text = 64'hFFFFFFFFFFFFFFFF;
    recv_word("b2b_w0", 64'h0123456789ABCDEF, 8'hFF);
    wait_ready(acc2_c);
    check("b2b_accept_gap", 64'(acc2_c - acc_c), 64'(READY_LAT));
    @(negedge clk);
    cipher_valid = 1'b0;
    recv_word("b2b_w1", 64'hFFFFFFFFFFFFFFFF, 8'h00);
    wait_ready(rdy_c);
    check("b2b_ready_lat", 64'(rdy_c - acc2_c), 64'(READY_LAT));

    // Input changes after the transfer edge are ignored.
    send(64'h85E813540F0AB405, acc_c);
    fork
      begin
        repeat (19) @(negedge clk);
        cipher_text = 64'd0;
      end
    join_none
    recv_word("ignore", 64'h85E813540F0AB405, 8'b10110000);
    wait_ready(rdy_c);

    // Reset in the middle of a word: line idles at once and nothing resumes.
    send(64'h0123456789ABCDEF, acc_c);
    repeat (349) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_txd", {63'd0, txd}, 64'd1);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, cipher_ready}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", {63'd0, cipher_ready}, 64'd1);
    falls = 0;
    prev  = txd;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && txd === 1'b0) falls++;
      prev = txd;
    end
    check("midrst_no_falls", 64'(falls), 64'd0);
    check("midrst_idle_busy", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
